// File: rtl/feature_stream_loader_if.sv
// Purpose: bundles the control, byte-lane stream and feature-memory write port of feature_stream_loader.
// Ports: start_i/base_addr_i/num_words_i (load request), s_data_i/s_valid_i/s_last_i/s_ready_o (stream),
//        mem_data_o/wr_addrs_mem_o/wr_mem_ld_o (memory write), busy_o/done_o/input_ready_o/words_written_o (status).
// The slave modport is the loader itself; the master modport is whatever drives it.
interface feature_stream_loader_if #(
    parameter int N_ROWS_ARRAY = 16,
    parameter int I_WIDTH      = 8,
    parameter int BEAT_LANES   = 4,
    parameter int ADDR_WIDTH   = 16
);
    logic                            start_i;
    logic [ADDR_WIDTH-1:0]           base_addr_i;
    logic [ADDR_WIDTH-1:0]           num_words_i;
    logic [BEAT_LANES*I_WIDTH-1:0]   s_data_i;
    logic                            s_valid_i;
    logic                            s_last_i;
    logic                            s_ready_o;
    logic [N_ROWS_ARRAY*I_WIDTH-1:0] mem_data_o;
    logic [ADDR_WIDTH-1:0]           wr_addrs_mem_o;
    logic                            wr_mem_ld_o;
    logic                            busy_o;
    logic                            done_o;
    logic                            input_ready_o;
    logic [ADDR_WIDTH-1:0]           words_written_o;

    modport master (
        output start_i, base_addr_i, num_words_i, s_data_i, s_valid_i, s_last_i,
        input  s_ready_o, mem_data_o, wr_addrs_mem_o, wr_mem_ld_o,
               busy_o, done_o, input_ready_o, words_written_o
    );

    modport slave (
        input  start_i, base_addr_i, num_words_i, s_data_i, s_valid_i, s_last_i,
        output s_ready_o, mem_data_o, wr_addrs_mem_o, wr_mem_ld_o,
               busy_o, done_o, input_ready_o, words_written_o
    );
endinterface

// File: rtl/feature_stream_loader.sv
// Purpose: packs a BEAT_LANES-wide byte-lane stream into N_ROWS_ARRAY-lane feature-memory words and writes a block of them.
// Latency: write strobe 1 cycle after the completing beat; BEATS_PER_WORD+1 cycles per word; done_o 1 cycle after last strobe.
// Backpressure: s_ready_o is high only in FILL; beats beyond the programmed block or after s_last_i stay pending upstream.
// Ports: clk_i, general_rst_i (synchronous, active-low), bus (slave side of feature_stream_loader_if).
module feature_stream_loader #(
    parameter int N_ROWS_ARRAY = 16,
    parameter int I_WIDTH      = 8,
    parameter int BEAT_LANES   = 4,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                    clk_i,
    input  logic                    general_rst_i,
    feature_stream_loader_if.slave  bus
);
    localparam int BEATS_PER_WORD = N_ROWS_ARRAY / BEAT_LANES;
    localparam int CNT_W          = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
    localparam int BEAT_W         = BEAT_LANES * I_WIDTH;
    localparam int WORD_W         = N_ROWS_ARRAY * I_WIDTH;

    generate
        if (N_ROWS_ARRAY % BEAT_LANES != 0) begin : g_bad_cfg
            $error("feature_stream_loader: N_ROWS_ARRAY must be a multiple of BEAT_LANES");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_W-1:0]      pack_q;
    logic [CNT_W-1:0]       lane_cnt_q;
    logic                   last_seen_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  remaining_q;
    logic [ADDR_WIDTH-1:0]  words_q;
    logic                   input_ready_q;

    logic start_load;   // accepted start with a non-zero word count
    logic start_zero;   // accepted start with a zero word count
    logic beat_acc;
    logic word_full;
    logic s_ready;
    logic wr_ld;
    logic done;

    always_ff @(posedge clk_i) begin
        if (!general_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_load = 1'b0;
        start_zero = 1'b0;
        beat_acc   = 1'b0;
        word_full  = 1'b0;
        s_ready    = 1'b0;
        wr_ld      = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.num_words_i != '0) begin
                        start_load = 1'b1;
                        state_d    = FILL;
                    end else begin
                        start_zero = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            FILL: begin
                s_ready   = 1'b1;
                beat_acc  = bus.s_valid_i;
                word_full = (lane_cnt_q == CNT_W'(BEATS_PER_WORD - 1));
                // A short final word is committed as soon as s_last_i lands.
                if (beat_acc && (word_full || bus.s_last_i)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wr_ld   = 1'b1;
                state_d = (remaining_q == ADDR_WIDTH'(1) || last_seen_q) ? DONE : FILL;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!general_rst_i) begin
            pack_q        <= '0;
            lane_cnt_q    <= '0;
            last_seen_q   <= 1'b0;
            addr_q        <= '0;
            remaining_q   <= '0;
            words_q       <= '0;
            input_ready_q <= 1'b0;
        end else begin
            if (start_load || start_zero) begin
                pack_q        <= '0;
                lane_cnt_q    <= '0;
                last_seen_q   <= 1'b0;
                words_q       <= '0;
                input_ready_q <= 1'b0;
            end
            if (start_load) begin
                addr_q      <= bus.base_addr_i;
                remaining_q <= bus.num_words_i;
            end
            if (beat_acc) begin
                // Lane k of the beat lands at word lane lane_cnt*BEAT_LANES+k; unfilled lanes stay zero.
                pack_q[int'(lane_cnt_q) * BEAT_W +: BEAT_W] <= bus.s_data_i;
                lane_cnt_q <= lane_cnt_q + CNT_W'(1);
                if (bus.s_last_i) begin
                    last_seen_q <= 1'b1;
                end
            end
            if (wr_ld) begin
                addr_q      <= addr_q + ADDR_WIDTH'(1);  // wraps at 2^ADDR_WIDTH
                remaining_q <= remaining_q - ADDR_WIDTH'(1);
                words_q     <= words_q + ADDR_WIDTH'(1);
                pack_q      <= '0;
                lane_cnt_q  <= '0;
            end
            if (done) begin
                input_ready_q <= 1'b1;
            end
        end
    end

    // Every output is a decode of, or a copy of, a register.
    assign bus.s_ready_o       = s_ready;
    assign bus.wr_mem_ld_o     = wr_ld;
    assign bus.done_o          = done;
    assign bus.busy_o          = (state_q != IDLE);
    assign bus.mem_data_o      = pack_q;
    assign bus.wr_addrs_mem_o  = addr_q;
    assign bus.words_written_o = words_q;
    assign bus.input_ready_o   = input_ready_q;

endmodule

// File: tb/tb_feature_stream_loader.sv
// Purpose: self-checking bench for feature_stream_loader against a word-grouping reference model.
// Latency: checks strobe spacing, done timing and reset response cycle by cycle.
// Backpressure: drives continuous, alternating and random s_valid_i patterns.
module tb_feature_stream_loader;
    localparam int N   = 16;
    localparam int IW  = 8;
    localparam int BL  = 4;
    localparam int AW  = 16;
    localparam int BPW = N / BL;
    localparam int WW  = N * IW;
    localparam int BW  = BL * IW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    feature_stream_loader_if #(.N_ROWS_ARRAY(N), .I_WIDTH(IW), .BEAT_LANES(BL), .ADDR_WIDTH(AW)) bus ();

    feature_stream_loader #(
        .N_ROWS_ARRAY(N), .I_WIDTH(IW), .BEAT_LANES(BL), .ADDR_WIDTH(AW)
    ) dut (
        .clk_i         (clk),
        .general_rst_i (rst_n),
        .bus           (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [BW-1:0] beat_dat [64];
    bit            beat_last[64];

    logic [AW-1:0] got_addr[$];
    logic [WW-1:0] got_word[$];
    int            got_cyc [$];
    logic [AW-1:0] exp_addr[$];
    logic [WW-1:0] exp_word[$];
    int            exp_beats;

    int done_cnt  = 0;
    int rdy_in_wr = 0;
    int cyc       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.wr_mem_ld_o === 1'b1) begin
            got_addr.push_back(bus.wr_addrs_mem_o);
            got_word.push_back(bus.mem_data_o);
            got_cyc.push_back(cyc);
        end
        if (bus.done_o === 1'b1) done_cnt++;
        if (bus.wr_mem_ld_o === 1'b1 && bus.s_ready_o === 1'b1) rdy_in_wr++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    // Reference model: group beats into words in stream order, stop after
    // num words or after the beat flagged last; unfilled lanes are zero.
    task automatic build_expect(input logic [AW-1:0] base, input int num, input int nbeats);
        logic [WW-1:0] word;
        int  idx;
        int  w;
        bit  stop;
        exp_addr.delete();
        exp_word.delete();
        idx  = 0;
        w    = 0;
        stop = 0;
        while (w < num && idx < nbeats && !stop) begin
            word = '0;
            for (int j = 0; j < BPW; j++) begin
                if (!stop && idx < nbeats) begin
                    word[j*BW +: BW] = beat_dat[idx];
                    stop = beat_last[idx];
                    idx++;
                end
            end
            exp_addr.push_back(base + AW'(w));
            exp_word.push_back(word);
            w++;
        end
        exp_beats = idx;
    endtask

    task automatic fill_ramp(input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            beat_dat[b]  = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
            beat_last[b] = 1'b0;
        end
    endtask

    task automatic fill_random(input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            beat_dat[b]  = $urandom;
            beat_last[b] = 1'b0;
        end
    endtask

    // gap_mode: 0 continuous, 1 valid every other cycle, 2 random.
    task automatic drive_load(input logic [AW-1:0] base, input logic [AW-1:0] num, input int nbeats,
                              input int gap_mode, input bit poke, output int accepted);
        int b;
        int n;
        int d0;
        bit acc;
        got_addr.delete();
        got_word.delete();
        got_cyc.delete();
        d0 = done_cnt;
        b  = 0;
        n  = 0;
        @(posedge clk); #1;
        bus.start_i     = 1'b1;
        bus.base_addr_i = base;
        bus.num_words_i = num;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        while (done_cnt == d0 && n < 500) begin
            bus.start_i = poke && (n == 2);
            if (poke && n == 2) begin
                bus.base_addr_i = 16'h5555;
                bus.num_words_i = 16'd7;
            end
            bus.s_valid_i = (b < nbeats) && (gap_mode == 0 || (gap_mode == 1 && n % 2 == 0) ||
                                             (gap_mode == 2 && $urandom_range(1, 0) == 1));
            bus.s_data_i  = (b < nbeats) ? beat_dat[b] : '0;
            bus.s_last_i  = (b < nbeats) ? beat_last[b] : 1'b0;
            @(negedge clk);
            acc = bus.s_valid_i && bus.s_ready_o;
            @(posedge clk); #1;
            if (acc) b++;
            n++;
        end
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
        bus.start_i   = 1'b0;
        accepted = b;
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL load_timeout: got no done_o within 500 cycles, required done_o");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_i = 0; bus.base_addr_i = '0; bus.num_words_i = '0;
        bus.s_data_i = '0; bus.s_valid_i = 0; bus.s_last_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.s_ready_o, bus.wr_mem_ld_o, bus.done_o, bus.input_ready_o, bus.busy_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {bus.s_ready_o, bus.wr_mem_ld_o, bus.done_o, bus.input_ready_o, bus.busy_o});
        end
        checks++;
        if (bus.mem_data_o !== '0 || bus.wr_addrs_mem_o !== '0 || bus.words_written_o !== '0) begin
            failures++;
            $display("FAIL reset_buses: got data=%h addr=%h words=%h, required all zero",
                     bus.mem_data_o, bus.wr_addrs_mem_o, bus.words_written_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        int d0;
        int acc;
        fill_ramp(8);
        build_expect(16'h0010, 2, 8);
        d0 = done_cnt;
        drive_load(16'h0010, 16'd2, 8, 0, 1'b0, acc);
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL normal_count: got %0d strobes, required %0d", got_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                checks++;
                if (got_addr[i] !== exp_addr[i] || got_word[i] !== exp_word[i]) begin
                    failures++;
                    $display("FAIL normal_word%0d: got %h@%h, required %h@%h", i, got_word[i], got_addr[i], exp_word[i], exp_addr[i]);
                end
            end
        end
        checks++;
        if (got_word.size() < 1 || got_word[0] !== 128'h0F0E0D0C0B0A09080706050403020100 || got_addr[0] !== 16'h0010) begin
            failures++;
            $display("FAIL normal_lane_order: got first word %h, required 0f0e..0100 at 0010",
                     got_word.size() > 0 ? got_word[0] : '0);
        end
        checks++;
        if (got_cyc.size() < 2 || got_cyc[1] - got_cyc[0] != BPW + 1) begin
            failures++;
            $display("FAIL normal_rate: got strobe spacing %0d, required %0d",
                     got_cyc.size() > 1 ? got_cyc[1] - got_cyc[0] : -1, BPW + 1);
        end
        checks++;
        if (done_cnt - d0 != 1 || bus.input_ready_o !== 1'b1 || bus.words_written_o !== 16'd2 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL normal_status: got done=%0d ready=%b words=%0d busy=%b, required 1 1 2 0",
                     done_cnt - d0, bus.input_ready_o, bus.words_written_o, bus.busy_o);
        end
        checks++;
        if (acc != exp_beats) begin
            failures++;
            $display("FAIL normal_beats: got %0d beats accepted, required %0d", acc, exp_beats);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        fill_ramp(8);
        build_expect(16'h0010, 2, 8);
        drive_load(16'h0010, 16'd2, 8, 1, 1'b0, acc);
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL bp_count: got %0d strobes, required %0d", got_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                checks++;
                if (got_addr[i] !== exp_addr[i] || got_word[i] !== exp_word[i]) begin
                    failures++;
                    $display("FAIL bp_word%0d: got %h@%h, required %h@%h", i, got_word[i], got_addr[i], exp_word[i], exp_addr[i]);
                end
            end
        end
        checks++;
        if (rdy_in_wr != 0) begin
            failures++;
            $display("FAIL bp_ready_in_write: got %0d cycles with s_ready_o in WRITE, required 0", rdy_in_wr);
        end
    endtask

    task automatic test_early_last();
        int acc;
        fill_ramp(4);
        beat_dat[4]  = 32'hAABBCCDD;
        beat_last[4] = 1'b1;
        for (int b = 5; b < 8; b++) begin
            beat_dat[b]  = $urandom;
            beat_last[b] = 1'b0;
        end
        build_expect(16'h0100, 3, 8);
        drive_load(16'h0100, 16'd3, 8, 0, 1'b0, acc);
        checks++;
        if (got_addr.size() != 2 || got_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL early_count: got %0d strobes, required 2", got_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                checks++;
                if (got_addr[i] !== exp_addr[i] || got_word[i] !== exp_word[i]) begin
                    failures++;
                    $display("FAIL early_word%0d: got %h@%h, required %h@%h", i, got_word[i], got_addr[i], exp_word[i], exp_addr[i]);
                end
            end
            checks++;
            if (got_word[1] !== {96'h0, 32'hAABBCCDD} || got_addr[1] !== 16'h0101) begin
                failures++;
                $display("FAIL early_pad: got %h@%h, required zero-padded aabbccdd at 0101", got_word[1], got_addr[1]);
            end
        end
        checks++;
        if (acc != 5 || bus.words_written_o !== 16'd2) begin
            failures++;
            $display("FAIL early_status: got beats=%0d words=%0d, required 5 2", acc, bus.words_written_o);
        end
    endtask

    task automatic test_addr_wrap();
        int acc;
        fill_random(8);
        build_expect(16'hFFFF, 2, 8);
        drive_load(16'hFFFF, 16'd2, 8, 0, 1'b0, acc);
        checks++;
        if (got_addr.size() != 2 || got_addr[0] !== 16'hFFFF || got_addr[1] !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_addr: got %0d strobes first=%h, required ffff then 0000",
                     got_addr.size(), got_addr.size() > 0 ? got_addr[0] : 16'h0);
        end else begin
            foreach (exp_word[i]) begin
                checks++;
                if (got_word[i] !== exp_word[i]) begin
                    failures++;
                    $display("FAIL wrap_word%0d: got %h, required %h", i, got_word[i], exp_word[i]);
                end
            end
        end
    endtask

    task automatic test_zero_count();
        got_addr.delete();
        @(posedge clk); #1;
        bus.start_i     = 1'b1;
        bus.base_addr_i = 16'h1234;
        bus.num_words_i = 16'd0;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.wr_mem_ld_o !== 1'b0 || bus.input_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: got done=%b busy=%b ld=%b ready=%b, required 1 1 0 0",
                     bus.done_o, bus.busy_o, bus.wr_mem_ld_o, bus.input_ready_o);
        end
        @(negedge clk);
        checks++;
        if (bus.done_o !== 1'b0 || bus.input_ready_o !== 1'b1 || bus.busy_o !== 1'b0 ||
            bus.words_written_o !== 16'd0 || got_addr.size() != 0) begin
            failures++;
            $display("FAIL zero_after: got done=%b ready=%b busy=%b words=%0d strobes=%0d, required 0 1 0 0 0",
                     bus.done_o, bus.input_ready_o, bus.busy_o, bus.words_written_o, got_addr.size());
        end
    endtask

    task automatic test_ignored_start();
        int acc;
        fill_ramp(8);
        build_expect(16'h0040, 2, 8);
        drive_load(16'h0040, 16'd2, 8, 0, 1'b1, acc);
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL ignstart_count: got %0d strobes, required %0d", got_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                checks++;
                if (got_addr[i] !== exp_addr[i] || got_word[i] !== exp_word[i]) begin
                    failures++;
                    $display("FAIL ignstart_word%0d: got %h@%h, required %h@%h", i, got_word[i], got_addr[i], exp_word[i], exp_addr[i]);
                end
            end
        end
        checks++;
        if (bus.words_written_o !== 16'd2 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL ignstart_status: got words=%0d busy=%b, required 2 0", bus.words_written_o, bus.busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int  b;
        int  n;
        int  acc;
        bit  hs;
        fill_ramp(8);
        got_addr.delete();
        got_word.delete();
        got_cyc.delete();
        @(posedge clk); #1;
        bus.start_i     = 1'b1;
        bus.base_addr_i = 16'h0200;
        bus.num_words_i = 16'd2;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        b = 0;
        n = 0;
        while (b < 2 && n < 20) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = beat_dat[b];
            bus.s_last_i  = 1'b0;
            @(negedge clk);
            hs = bus.s_ready_o;
            @(posedge clk); #1;
            if (hs) b++;
            n++;
        end
        bus.s_valid_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.s_ready_o, bus.wr_mem_ld_o, bus.done_o, bus.input_ready_o, bus.busy_o} !== 5'b0 ||
            bus.mem_data_o !== '0 || bus.wr_addrs_mem_o !== '0 || bus.words_written_o !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got flags=%b data=%h addr=%h words=%h, required all zero",
                     {bus.s_ready_o, bus.wr_mem_ld_o, bus.done_o, bus.input_ready_o, bus.busy_o},
                     bus.mem_data_o, bus.wr_addrs_mem_o, bus.words_written_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got_addr.size() != 0 || b != 2) begin
            failures++;
            $display("FAIL midreset_nostrobe: got %0d strobes after %0d beats, required 0 after 2", got_addr.size(), b);
        end
        fill_random(4);
        build_expect(16'h0300, 1, 4);
        drive_load(16'h0300, 16'd1, 4, 0, 1'b0, acc);
        checks++;
        if (got_addr.size() != 1 || got_addr[0] !== exp_addr[0] || got_word[0] !== exp_word[0] ||
            bus.input_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL midreset_reload: got %0d strobes ready=%b, required 1 strobe %h@%h ready=1",
                     got_addr.size(), bus.input_ready_o, exp_word[0], exp_addr[0]);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] base;
        int num;
        int nbeats;
        int acc;
        int d0;
        for (int it = 0; it < 8; it++) begin
            base   = AW'($urandom);
            num    = $urandom_range(4, 1);
            nbeats = num * BPW + 2;
            fill_random(nbeats);
            if ($urandom_range(1, 0) == 1) beat_last[$urandom_range(nbeats - 1, 0)] = 1'b1;
            build_expect(base, num, nbeats);
            d0 = done_cnt;
            drive_load(base, AW'(num), nbeats, 2, 1'b0, acc);
            checks++;
            if (got_addr.size() != exp_addr.size()) begin
                failures++;
                $display("FAIL rand%0d_count: got %0d strobes, required %0d", it, got_addr.size(), exp_addr.size());
            end else begin
                foreach (exp_addr[i]) begin
                    checks++;
                    if (got_addr[i] !== exp_addr[i] || got_word[i] !== exp_word[i]) begin
                        failures++;
                        $display("FAIL rand%0d_word%0d: got %h@%h, required %h@%h", it, i, got_word[i], got_addr[i], exp_word[i], exp_addr[i]);
                    end
                end
            end
            checks++;
            if (acc != exp_beats || bus.words_written_o !== AW'(exp_addr.size()) ||
                bus.input_ready_o !== 1'b1 || done_cnt - d0 != 1) begin
                failures++;
                $display("FAIL rand%0d_status: got beats=%0d words=%0d ready=%b done=%0d, required %0d %0d 1 1",
                         it, acc, bus.words_written_o, bus.input_ready_o, done_cnt - d0, exp_beats, exp_addr.size());
            end
        end
        checks++;
        if (rdy_in_wr != 0) begin
            failures++;
            $display("FAIL rand_ready_in_write: got %0d, required 0", rdy_in_wr);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_early_last();
        test_addr_wrap();
        test_zero_count();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
